// File: rtl/execute_md_stage.sv
// Execute stage: ID/EX pipeline register with operand forwarding, a single-cycle
// integer ALU and an iterative multiply/divide unit that owns HI/LO.
module execute_md_stage #(
   parameter int XLEN     = 32,
   parameter int RADDR_W  = 5,
   parameter int LINK_REG = 31
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               valid_d,
   input  logic               flush,
   input  logic               stall_in,
   input  logic [XLEN-1:0]    rd1_d,
   input  logic [XLEN-1:0]    rd2_d,
   input  logic               fwd_a_en,
   input  logic               fwd_b_en,
   input  logic [XLEN-1:0]    fwd_a,
   input  logic [XLEN-1:0]    fwd_b,
   input  logic [XLEN-1:0]    imm_d,
   input  logic [4:0]         shamt_d,
   input  logic [XLEN-1:0]    pc_plus4_d,
   input  logic [RADDR_W-1:0] dst_d,
   input  logic               reg_write_d,
   input  logic               mem_read_d,
   input  logic               mem_write_d,
   input  logic               link_d,
   input  logic [1:0]         src_sel_d,
   input  logic [3:0]         alu_op_d,
   input  logic [3:0]         md_op_d,
   output logic               valid_e,
   output logic [XLEN-1:0]    result_e,
   output logic [XLEN-1:0]    store_data_e,
   output logic [RADDR_W-1:0] dst_e,
   output logic               reg_write_e,
   output logic               mem_read_e,
   output logic               mem_write_e,
   output logic               zero_e,
   output logic [XLEN-1:0]    pc_branch_e,
   output logic               stall_out
);

   localparam int CW = $clog2(XLEN);

   localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR = 4'd3;
   localparam logic [3:0] ALU_XOR = 4'd4, ALU_NOR = 4'd5, ALU_SLT = 4'd6, ALU_SLTU = 4'd7;
   localparam logic [3:0] ALU_SLL = 4'd8, ALU_SRL = 4'd9, ALU_SRA = 4'd10, ALU_LUI = 4'd11;

   localparam logic [3:0] MD_MULT = 4'd1, MD_MULTU = 4'd2, MD_DIV = 4'd3, MD_DIVU = 4'd4;
   localparam logic [3:0] MD_MFHI = 4'd5, MD_MFLO = 4'd6, MD_MTHI = 4'd7, MD_MTLO = 4'd8;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} mdState_t;

   logic               valid_q;
   logic [XLEN-1:0]    op1_q, op2_q, imm_q, pcPlus4_q, pcBranch_q;
   logic [4:0]         shamt_q;
   logic [RADDR_W-1:0] dst_q;
   logic               regWrite_q, memRead_q, memWrite_q, link_q;
   logic [1:0]         srcSel_q;
   logic [3:0]         aluOp_q, mdOp_q;

   mdState_t           state_q, state_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [XLEN-1:0]    accHi_q, accHi_d, accLo_q, accLo_d, mcand_q, mcand_d;
   logic [XLEN-1:0]    hi_q, hi_d, lo_q, lo_d;

   logic               isMulDiv, isMult, isSigned, op1Neg, op2Neg;
   logic               stallOut, hold, mdWrite, slotValid;
   logic [XLEN-1:0]    absOp1, absOp2;
   logic [XLEN:0]      prodSum, remShift;
   logic [XLEN-1:0]    remDiff, quoFix, remFix, mdHi, mdLo;
   logic [2*XLEN-1:0]  prodRaw, prodFix;
   logic [XLEN-1:0]    aluA, aluB, aluRes;
   logic [4:0]         shAmt;

   always_comb begin
      isMulDiv  = (mdOp_q >= MD_MULT) && (mdOp_q <= MD_DIVU);
      isMult    = (mdOp_q == MD_MULT) || (mdOp_q == MD_MULTU);
      isSigned  = (mdOp_q == MD_MULT) || (mdOp_q == MD_DIV);
      stallOut  = ((state_q == IDLE) && valid_q && isMulDiv) || (state_q == BUSY);
      hold      = stall_in || stallOut;
      mdWrite   = (state_q == DONE) && !stall_in && !flush;
      slotValid = valid_q && !stallOut;
      op1Neg    = isSigned && op1_q[XLEN-1];
      op2Neg    = isSigned && op2_q[XLEN-1];
      absOp1    = op1Neg ? -op1_q : op1_q;
      absOp2    = op2Neg ? -op2_q : op2_q;
   end

   // One shift-add or restoring-subtract step; the magnitudes are signed-fixed in DONE
   always_comb begin
      prodSum  = {1'b0, accHi_q} + (accLo_q[0] ? {1'b0, mcand_q} : '0);
      remShift = {accHi_q, accLo_q[XLEN-1]};
      remDiff  = remShift[XLEN-1:0] - mcand_q;
      prodRaw  = {accHi_q, accLo_q};
      prodFix  = (op1Neg ^ op2Neg) ? -prodRaw : prodRaw;
      quoFix   = (op1Neg ^ op2Neg) ? -accLo_q : accLo_q;
      remFix   = op1Neg ? -accHi_q : accHi_q;
      if (isMult) begin
         {mdHi, mdLo} = prodFix;
      end else if (op2_q == '0) begin
         mdHi = op1_q;
         mdLo = '1;
      end else begin
         mdHi = remFix;
         mdLo = quoFix;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      accHi_d = accHi_q;
      accLo_d = accLo_q;
      mcand_d = mcand_q;
      case (state_q)
         IDLE: begin
            if (valid_q && isMulDiv) begin
               state_d = BUSY;
               cnt_d   = CW'(XLEN - 1);
               accHi_d = '0;
               accLo_d = absOp1;
               mcand_d = absOp2;
            end
         end
         BUSY: begin
            if (isMult) begin
               {accHi_d, accLo_d} = {prodSum, accLo_q[XLEN-1:1]};
            end else if (remShift >= {1'b0, mcand_q}) begin
               accHi_d = remDiff;
               accLo_d = {accLo_q[XLEN-2:0], 1'b1};
            end else begin
               accHi_d = remShift[XLEN-1:0];
               accLo_d = {accLo_q[XLEN-2:0], 1'b0};
            end
            if (cnt_q == '0) state_d = DONE;
            else             cnt_d   = cnt_q - CW'(1);
         end
         DONE: begin
            if (!stall_in) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      if (flush) state_d = IDLE;
   end

   // HI/LO change only as an instruction actually leaves EX
   always_comb begin
      hi_d = hi_q;
      lo_d = lo_q;
      if (mdWrite) begin
         hi_d = mdHi;
         lo_d = mdLo;
      end else if (valid_q && !hold && !flush) begin
         if (mdOp_q == MD_MTHI) hi_d = op1_q;
         if (mdOp_q == MD_MTLO) lo_d = op1_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         accHi_q <= '0;
         accLo_q <= '0;
         mcand_q <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         accHi_q <= accHi_d;
         accLo_q <= accLo_d;
         mcand_q <= mcand_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q    <= 1'b0;
         op1_q      <= '0;
         op2_q      <= '0;
         imm_q      <= '0;
         shamt_q    <= '0;
         pcPlus4_q  <= '0;
         pcBranch_q <= '0;
         dst_q      <= '0;
         regWrite_q <= 1'b0;
         memRead_q  <= 1'b0;
         memWrite_q <= 1'b0;
         link_q     <= 1'b0;
         srcSel_q   <= '0;
         aluOp_q    <= '0;
         mdOp_q     <= '0;
      end else if (flush) begin
         valid_q <= 1'b0;
      end else if (!hold) begin
         valid_q    <= valid_d;
         op1_q      <= fwd_a_en ? fwd_a : rd1_d;
         op2_q      <= fwd_b_en ? fwd_b : rd2_d;
         imm_q      <= imm_d;
         shamt_q    <= shamt_d;
         pcPlus4_q  <= pc_plus4_d;
         pcBranch_q <= pc_plus4_d + (imm_d << 2);
         dst_q      <= dst_d;
         regWrite_q <= reg_write_d;
         memRead_q  <= mem_read_d;
         memWrite_q <= mem_write_d;
         link_q     <= link_d;
         srcSel_q   <= src_sel_d;
         aluOp_q    <= alu_op_d;
         mdOp_q     <= md_op_d;
      end
   end

   // Shifts take the value from B and the amount from A, MIPS style
   always_comb begin
      aluA  = srcSel_q[0] ? {{(XLEN-5){1'b0}}, shamt_q} : op1_q;
      aluB  = srcSel_q[1] ? imm_q : op2_q;
      shAmt = aluA[4:0];
      case (aluOp_q)
         ALU_ADD:  aluRes = aluA + aluB;
         ALU_SUB:  aluRes = aluA - aluB;
         ALU_AND:  aluRes = aluA & aluB;
         ALU_OR:   aluRes = aluA | aluB;
         ALU_XOR:  aluRes = aluA ^ aluB;
         ALU_NOR:  aluRes = ~(aluA | aluB);
         ALU_SLT:  aluRes = {{(XLEN-1){1'b0}}, ($signed(aluA) < $signed(aluB))};
         ALU_SLTU: aluRes = {{(XLEN-1){1'b0}}, (aluA < aluB)};
         ALU_SLL:  aluRes = aluB << shAmt;
         ALU_SRL:  aluRes = aluB >> shAmt;
         ALU_SRA:  aluRes = $signed(aluB) >>> shAmt;
         ALU_LUI:  aluRes = aluB << 16;
         default:  aluRes = '0;
      endcase
   end

   always_comb begin
      if (link_q)                  result_e = pcPlus4_q + XLEN'(4);
      else if (mdOp_q == MD_MFHI)  result_e = hi_q;
      else if (mdOp_q == MD_MFLO)  result_e = lo_q;
      else                         result_e = aluRes;
      valid_e      = slotValid;
      store_data_e = op2_q;
      dst_e        = link_q ? RADDR_W'(LINK_REG) : dst_q;
      reg_write_e  = regWrite_q && slotValid;
      mem_read_e   = memRead_q && slotValid;
      mem_write_e  = memWrite_q && slotValid;
      zero_e       = (aluRes == '0) && slotValid;
      pc_branch_e  = pcBranch_q;
      stall_out    = stallOut;
   end

endmodule

// File: tb/tb_execute_md_stage.sv
// Self-checking bench for execute_md_stage: directed instructions against an
// instruction-level model of the EX slot and HI/LO, plus literal spot checks.
module tb_execute_md_stage;

   localparam int XLEN     = 32;
   localparam int RADDR_W  = 5;
   localparam int LINK_REG = 31;

   logic clk = 1'b0;
   logic rst, valid_d, flush, stall_in, fwd_a_en, fwd_b_en;
   logic reg_write_d, mem_read_d, mem_write_d, link_d;
   logic [31:0] rd1_d, rd2_d, fwd_a, fwd_b, imm_d, pc_plus4_d;
   logic [4:0]  shamt_d, dst_d;
   logic [1:0]  src_sel_d;
   logic [3:0]  alu_op_d, md_op_d;
   logic        valid_e, reg_write_e, mem_read_e, mem_write_e, zero_e, stall_out;
   logic [31:0] result_e, store_data_e, pc_branch_e;
   logic [4:0]  dst_e;

   always #5 clk = ~clk;

   execute_md_stage #(.XLEN(XLEN), .RADDR_W(RADDR_W), .LINK_REG(LINK_REG)) dut (
      .clk(clk), .rst(rst), .valid_d(valid_d), .flush(flush), .stall_in(stall_in),
      .rd1_d(rd1_d), .rd2_d(rd2_d), .fwd_a_en(fwd_a_en), .fwd_b_en(fwd_b_en),
      .fwd_a(fwd_a), .fwd_b(fwd_b), .imm_d(imm_d), .shamt_d(shamt_d),
      .pc_plus4_d(pc_plus4_d), .dst_d(dst_d), .reg_write_d(reg_write_d),
      .mem_read_d(mem_read_d), .mem_write_d(mem_write_d), .link_d(link_d),
      .src_sel_d(src_sel_d), .alu_op_d(alu_op_d), .md_op_d(md_op_d),
      .valid_e(valid_e), .result_e(result_e), .store_data_e(store_data_e),
      .dst_e(dst_e), .reg_write_e(reg_write_e), .mem_read_e(mem_read_e),
      .mem_write_e(mem_write_e), .zero_e(zero_e), .pc_branch_e(pc_branch_e),
      .stall_out(stall_out)
   );

   typedef struct packed {
      logic        valid;
      logic [31:0] op1, op2, imm, pc4;
      logic [4:0]  shamt, dst;
      logic        rw, mr, mw, link;
      logic [1:0]  srcSel;
      logic [3:0]  aluOp, mdOp;
   } exModel_t;

   typedef struct packed {
      logic        valid, fa, fb;
      logic [31:0] rd1, rd2, fwdA, fwdB, imm, pc4;
      logic [4:0]  shamt, dst;
      logic        rw, mr, mw, link;
      logic [1:0]  srcSel;
      logic [3:0]  aluOp, mdOp;
   } dec_t;

   int          checks = 0;
   int          errors = 0;
   bit          checkEn = 1'b0;
   exModel_t    exM = '0;
   int          occ = 0;
   logic [31:0] mHi = '0;
   logic [31:0] mLo = '0;

   function automatic bit isMd(input logic [3:0] op);
      return (op >= 4'd1) && (op <= 4'd4);
   endfunction

   // A multiply/divide holds the pipe for XLEN+1 cycles after it enters EX
   function automatic bit mdBusy(input exModel_t x, input int o);
      return x.valid && isMd(x.mdOp) && (o < XLEN + 1);
   endfunction

   function automatic logic [31:0] modelAlu(input exModel_t x);
      logic [31:0] a, b;
      int sh;
      a  = x.srcSel[0] ? {27'b0, x.shamt} : x.op1;
      b  = x.srcSel[1] ? x.imm : x.op2;
      sh = int'(a[4:0]);
      case (x.aluOp)
         4'd0:  return a + b;
         4'd1:  return a - b;
         4'd2:  return a & b;
         4'd3:  return a | b;
         4'd4:  return a ^ b;
         4'd5:  return ~(a | b);
         4'd6:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         4'd7:  return (a < b) ? 32'd1 : 32'd0;
         4'd8:  return b << sh;
         4'd9:  return b >> sh;
         4'd10: return $signed(b) >>> sh;
         4'd11: return b << 16;
         default: return 32'd0;
      endcase
   endfunction

   // Returns {HI, LO} from plain 64-bit arithmetic
   function automatic logic [63:0] modelMulDiv(input exModel_t x);
      longint sa, sb;
      int da, db;
      logic [63:0] p;
      sa = longint'($signed(x.op1));
      sb = longint'($signed(x.op2));
      da = $signed(x.op1);
      db = $signed(x.op2);
      case (x.mdOp)
         4'd1: begin p = 64'(sa * sb); return p; end
         4'd2: begin p = {32'b0, x.op1} * {32'b0, x.op2}; return p; end
         4'd3: begin
            if (db == 0)                          return {x.op1, 32'hFFFF_FFFF};
            if (x.op1 == 32'h8000_0000 && db == -1) return {32'd0, 32'h8000_0000};
            return {32'(da % db), 32'(da / db)};
         end
         default: begin
            if (x.op2 == 0) return {x.op1, 32'hFFFF_FFFF};
            return {x.op1 % x.op2, x.op1 / x.op2};
         end
      endcase
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Instruction-level model of the EX slot and HI/LO
   always @(posedge clk) begin
      bit stallExp;
      logic [63:0] hl;
      stallExp = mdBusy(exM, occ);
      if (rst) begin
         exM = '0; occ = 0; mHi = '0; mLo = '0;
      end else if (flush) begin
         exM.valid = 1'b0; occ = 0;
      end else if (stall_in || stallExp) begin
         occ++;
      end else begin
         if (exM.valid) begin
            if (isMd(exM.mdOp)) begin
               hl = modelMulDiv(exM);
               mHi = hl[63:32];
               mLo = hl[31:0];
            end else if (exM.mdOp == 4'd7) mHi = exM.op1;
            else if (exM.mdOp == 4'd8)     mLo = exM.op1;
         end
         exM.valid  = valid_d;
         exM.op1    = fwd_a_en ? fwd_a : rd1_d;
         exM.op2    = fwd_b_en ? fwd_b : rd2_d;
         exM.imm    = imm_d;
         exM.pc4    = pc_plus4_d;
         exM.shamt  = shamt_d;
         exM.dst    = dst_d;
         exM.rw     = reg_write_d;
         exM.mr     = mem_read_d;
         exM.mw     = mem_write_d;
         exM.link   = link_d;
         exM.srcSel = src_sel_d;
         exM.aluOp  = alu_op_d;
         exM.mdOp   = md_op_d;
         occ = 0;
      end
   end

   always @(negedge clk) begin
      bit vs;
      logic [31:0] expRes;
      if (checkEn) begin
         vs = exM.valid && !mdBusy(exM, occ);
         checkOutput("valid_e", 32'(valid_e), 32'(vs));
         checkOutput("stall_out", 32'(stall_out), 32'(mdBusy(exM, occ)));
         checkOutput("reg_write_e", 32'(reg_write_e), 32'(exM.rw && vs));
         checkOutput("mem_read_e", 32'(mem_read_e), 32'(exM.mr && vs));
         checkOutput("mem_write_e", 32'(mem_write_e), 32'(exM.mw && vs));
         checkOutput("zero_e", 32'(zero_e), 32'((modelAlu(exM) == 32'd0) && vs));
         checkOutput("dst_e", 32'(dst_e), exM.link ? 32'(LINK_REG) : 32'(exM.dst));
         checkOutput("store_data_e", store_data_e, exM.op2);
         checkOutput("pc_branch_e", pc_branch_e, exM.pc4 + (exM.imm << 2));
         if (vs && !isMd(exM.mdOp) && exM.mdOp != 4'd7 && exM.mdOp != 4'd8) begin
            if (exM.link)               expRes = exM.pc4 + 32'd4;
            else if (exM.mdOp == 4'd5)  expRes = mHi;
            else if (exM.mdOp == 4'd6)  expRes = mLo;
            else                        expRes = modelAlu(exM);
            checkOutput("result_e", result_e, expRes);
         end
      end
   end

   task automatic clearDecode();
      valid_d = 0; fwd_a_en = 0; fwd_b_en = 0; rd1_d = 0; rd2_d = 0; fwd_a = 0; fwd_b = 0;
      imm_d = 0; shamt_d = 0; pc_plus4_d = 0; dst_d = 0; reg_write_d = 0; mem_read_d = 0;
      mem_write_d = 0; link_d = 0; src_sel_d = 0; alu_op_d = 0; md_op_d = 0;
   endtask

   // Presents one instruction in decode and waits until EX accepts it
   task automatic applyStimulus(input dec_t d, output int stalls);
      bit accepted;
      valid_d = d.valid; fwd_a_en = d.fa; fwd_b_en = d.fb; rd1_d = d.rd1; rd2_d = d.rd2;
      fwd_a = d.fwdA; fwd_b = d.fwdB; imm_d = d.imm; shamt_d = d.shamt; pc_plus4_d = d.pc4;
      dst_d = d.dst; reg_write_d = d.rw; mem_read_d = d.mr; mem_write_d = d.mw;
      link_d = d.link; src_sel_d = d.srcSel; alu_op_d = d.aluOp; md_op_d = d.mdOp;
      stalls = 0;
      accepted = 1'b0;
      for (int i = 0; i < 200 && !accepted; i++) begin
         @(negedge clk);
         if (!stall_out && !stall_in && !flush) accepted = 1'b1;
         else stalls++;
         @(posedge clk);
      end
      #1;
      if (!accepted) begin
         checks++;
         errors++;
         $display("[TB] FAIL accept timeout: got stalled expected accepted at %0t", $time);
      end
      clearDecode();
   endtask

   function automatic dec_t mkAlu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      dec_t d;
      d = '0;
      d.valid = 1'b1; d.rd1 = a; d.rd2 = b; d.aluOp = op; d.rw = 1'b1; d.dst = 5'd3;
      return d;
   endfunction

   function automatic dec_t mkMd(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      dec_t d;
      d = mkAlu(4'd0, a, b);
      d.mdOp = op;
      d.rw = (op == 4'd5) || (op == 4'd6);
      d.dst = 5'd4;
      return d;
   endfunction

   initial begin
      dec_t d;
      int s;
      clearDecode();
      rst = 1; flush = 0; stall_in = 0;
      @(posedge clk); #1;
      checkEn = 1'b1;
      checkOutput("reset valid_e", 32'(valid_e), 32'd0);
      checkOutput("reset stall_out", 32'(stall_out), 32'd0);
      checkOutput("reset zero_e", 32'(zero_e), 32'd0);
      checkOutput("reset result_e", result_e, 32'd0);
      @(posedge clk); #1;
      rst = 0;

      d = mkAlu(4'd0, 32'd99, 32'd7); d.fa = 1; d.fwdA = 32'd5;
      applyStimulus(d, s);
      checkOutput("add fwd result", result_e, 32'd12);
      checkOutput("add fwd valid_e", 32'(valid_e), 32'd1);
      checkOutput("add fwd zero_e", 32'(zero_e), 32'd0);

      d = mkAlu(4'd0, 32'd0, 32'd0); d.link = 1; d.pc4 = 32'h100; d.imm = 32'd4;
      applyStimulus(d, s);
      checkOutput("link result", result_e, 32'h104);
      checkOutput("link dst_e", 32'(dst_e), 32'd31);
      checkOutput("link reg_write_e", 32'(reg_write_e), 32'd1);
      checkOutput("link pc_branch_e", pc_branch_e, 32'h110);

      applyStimulus(mkAlu(4'd1, 32'd9, 32'd9), s);
      checkOutput("sub zero_e", 32'(zero_e), 32'd1);

      d = mkAlu(4'd10, 32'd0, 32'h8000_0000); d.srcSel = 2'b01; d.shamt = 5'd4;
      applyStimulus(d, s);
      checkOutput("sra shamt", result_e, 32'hF800_0000);

      d = mkAlu(4'd11, 32'd0, 32'd0); d.srcSel = 2'b10; d.imm = 32'h1234;
      applyStimulus(d, s);
      checkOutput("lui", result_e, 32'h1234_0000);

      applyStimulus(mkAlu(4'd6, 32'hFFFF_FFFF, 32'd1), s);
      checkOutput("slt", result_e, 32'd1);
      d = mkAlu(4'd7, 32'hFFFF_FFFF, 32'd0); d.fb = 1; d.fwdB = 32'd1;
      applyStimulus(d, s);
      checkOutput("sltu", result_e, 32'd0);
      applyStimulus(mkAlu(4'd5, 32'hF0F0_0000, 32'h0000_0F0F), s);
      applyStimulus(mkAlu(4'd9, 32'd3, 32'hF000_0000), s);

      d = mkAlu(4'd0, 32'h40, 32'hCAFE); d.srcSel = 2'b10; d.imm = 32'd8; d.rw = 0; d.mw = 1;
      applyStimulus(d, s);
      checkOutput("store data", store_data_e, 32'hCAFE);
      checkOutput("store mem_write_e", 32'(mem_write_e), 32'd1);
      checkOutput("store address", result_e, 32'h48);

      d = mkMd(4'd1, 32'd1, 32'd1); d.valid = 0;
      applyStimulus(d, s);
      checkOutput("bubble no stall", 32'(stall_out), 32'd0);

      applyStimulus(mkMd(4'd1, 32'hFFFF_FFFF, 32'd3), s);
      applyStimulus(mkMd(4'd5, 32'd0, 32'd0), s);
      checkOutput("mult stall cycles", 32'(s), 32'd33);
      checkOutput("mult mfhi", result_e, 32'hFFFF_FFFF);
      applyStimulus(mkMd(4'd6, 32'd0, 32'd0), s);
      checkOutput("mult mflo", result_e, 32'hFFFF_FFFD);

      applyStimulus(mkMd(4'd3, 32'hFFFF_FFF9, 32'd2), s);
      applyStimulus(mkMd(4'd6, 32'd0, 32'd0), s);
      checkOutput("div quotient", result_e, 32'hFFFF_FFFD);
      applyStimulus(mkMd(4'd5, 32'd0, 32'd0), s);
      checkOutput("div remainder", result_e, 32'hFFFF_FFFF);

      applyStimulus(mkMd(4'd4, 32'd9, 32'd0), s);
      applyStimulus(mkMd(4'd6, 32'd0, 32'd0), s);
      checkOutput("divu by zero lo", result_e, 32'hFFFF_FFFF);
      applyStimulus(mkMd(4'd5, 32'd0, 32'd0), s);
      checkOutput("divu by zero hi", result_e, 32'd9);

      applyStimulus(mkMd(4'd3, 32'h8000_0000, 32'hFFFF_FFFF), s);
      applyStimulus(mkMd(4'd6, 32'd0, 32'd0), s);
      checkOutput("div min lo", result_e, 32'h8000_0000);
      applyStimulus(mkMd(4'd5, 32'd0, 32'd0), s);
      checkOutput("div min hi", result_e, 32'd0);

      applyStimulus(mkMd(4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF), s);
      applyStimulus(mkMd(4'd5, 32'd0, 32'd0), s);
      checkOutput("multu hi", result_e, 32'hFFFF_FFFE);
      applyStimulus(mkMd(4'd6, 32'd0, 32'd0), s);
      checkOutput("multu lo", result_e, 32'd1);

      applyStimulus(mkMd(4'd7, 32'h1234, 32'd0), s);
      applyStimulus(mkMd(4'd8, 32'h5678, 32'd0), s);
      applyStimulus(mkMd(4'd5, 32'd0, 32'd0), s);
      checkOutput("mthi", result_e, 32'h1234);

      applyStimulus(mkMd(4'd2, 32'd7, 32'd7), s);
      repeat (10) @(posedge clk);
      #1;
      flush = 1;
      @(posedge clk); #1;
      flush = 0;
      checkOutput("flush stall_out", 32'(stall_out), 32'd0);
      checkOutput("flush valid_e", 32'(valid_e), 32'd0);
      applyStimulus(mkMd(4'd5, 32'd0, 32'd0), s);
      checkOutput("flush hi kept", result_e, 32'h1234);
      applyStimulus(mkMd(4'd6, 32'd0, 32'd0), s);
      checkOutput("flush lo kept", result_e, 32'h5678);

      applyStimulus(mkMd(4'd4, 32'd100, 32'd7), s);
      stall_in = 1;
      repeat (XLEN + 1) @(posedge clk);
      #1;
      for (int k = 0; k < 3; k++) begin
         checkOutput("done hold valid_e", 32'(valid_e), 32'd1);
         checkOutput("done hold stall_out", 32'(stall_out), 32'd0);
         if (k < 2) begin
            @(posedge clk); #1;
         end
      end
      stall_in = 0;
      applyStimulus(mkMd(4'd6, 32'd0, 32'd0), s);
      checkOutput("done hold lo", result_e, 32'd14);
      applyStimulus(mkMd(4'd5, 32'd0, 32'd0), s);
      checkOutput("done hold hi", result_e, 32'd2);

      repeat (2) @(posedge clk);
      #1;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
